// File: rtl/sdram_cmd_arbiter.sv
// Arbitrates NCH command channels onto a single SDRAM controller command port
// and routes the controller's read/write data strobes to the granted owner.
module sdram_cmd_arbiter #(
  parameter int NCH   = 3,
  parameter int CMDW  = 2,
  parameter int ADDRW = 23,
  parameter int MODE  = 0,
  parameter int TMO   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req_i,
  input  logic [NCH*CMDW-1:0]  cmd_i,
  input  logic [NCH*ADDRW-1:0] addr_i,
  output logic [CMDW-1:0]      sys_cmd_o,
  output logic [ADDRW-1:0]     sys_addr_o,
  input  logic [CMDW-1:0]      sys_cmd_ack_i,
  input  logic                 sys_rd_valid_i,
  input  logic                 sys_wr_valid_i,
  output logic [NCH-1:0]       gnt_o,
  output logic [NCH-1:0]       owner_o,
  output logic [NCH-1:0]       rd_valid_o,
  output logic [NCH-1:0]       wr_valid_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int IW = $clog2(NCH);
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t           state_q, state_n;
  logic [IW-1:0]    win_q, rp_q, rp_eff, sel_idx, rp_next;
  logic [CMDW-1:0]  cmd_q, ack_prev_q, sel_cmd;
  logic [ADDRW-1:0] addr_q, sel_addr;
  logic [CW-1:0]    cnt_q;
  logic [NCH-1:0]   gnt_q, owner_q, elig, win_oh;
  logic             err_q, found, ack_edge, load, ack_ok, ack_bad, timeout, idle_ack;

  always_comb begin
    elig = '0;
    for (int k = 0; k < NCH; k++) begin
      elig[k] = req_i[k] && (cmd_i[k*CMDW +: CMDW] != '0);
    end
  end

  assign rp_eff = (MODE == 1) ? rp_q : '0;

  // Round-robin as two priority passes: indices at/after rp first, then the
  // wrapped-around remainder. With rp forced to 0 this is plain fixed priority.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int j = 0; j < NCH; j++) begin
      if (!found && elig[j] && (IW'(j) >= rp_eff)) begin
        found   = 1'b1;
        sel_idx = IW'(j);
      end
    end
    for (int j = 0; j < NCH; j++) begin
      if (!found && elig[j]) begin
        found   = 1'b1;
        sel_idx = IW'(j);
      end
    end
  end

  always_comb begin
    sel_cmd  = '0;
    sel_addr = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_idx == IW'(k)) begin
        sel_cmd  = cmd_i[k*CMDW +: CMDW];
        sel_addr = addr_i[k*ADDRW +: ADDRW];
      end
    end
  end

  // Only a zero-to-nonzero transition of the acknowledge counts.
  assign ack_edge = (sys_cmd_ack_i != '0) && (ack_prev_q == '0);
  assign idle_ack = (state_q == IDLE) && ack_edge;
  assign win_oh   = NCH'(1) << win_q;
  assign rp_next  = (win_q == IW'(NCH - 1)) ? '0 : win_q + IW'(1);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state_q;
    load    = 1'b0;
    ack_ok  = 1'b0;
    ack_bad = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          load    = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (ack_edge && (sys_cmd_ack_i == cmd_q)) begin
          ack_ok  = 1'b1;
          state_n = IDLE;
        end else begin
          ack_bad = ack_edge;
          if (cnt_q == CW'(TMO - 1)) begin
            timeout = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // NOTE: the latched command/address are reset too, so nothing on the
  // controller port is ever undefined after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q      <= '0;
      rp_q       <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      ack_prev_q <= '0;
      gnt_q      <= '0;
      owner_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      ack_prev_q <= sys_cmd_ack_i;
      gnt_q      <= '0;
      if (load) begin
        win_q  <= sel_idx;
        cmd_q  <= sel_cmd;
        addr_q <= sel_addr;
        cnt_q  <= '0;
      end else if (state_q == ISSUE) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (ack_ok) begin
        gnt_q   <= win_oh;
        owner_q <= win_oh;
        if (MODE == 1) begin
          rp_q <= rp_next;
        end
      end
      if (ack_bad || timeout || idle_ack) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy_o     = (state_q == ISSUE);
  assign sys_cmd_o  = busy_o ? cmd_q : '0;
  assign sys_addr_o = busy_o ? addr_q : '0;
  assign gnt_o      = gnt_q;
  assign owner_o    = owner_q;
  assign err_o      = err_q;
  // Strobes follow the registered owner, so a same-cycle grant routes to the old owner.
  assign rd_valid_o = owner_q & {NCH{sys_rd_valid_i}};
  assign wr_valid_o = owner_q & {NCH{sys_wr_valid_i}};

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Self-checking bench for sdram_cmd_arbiter: a fixed-priority and a round-robin
// instance share channel stimulus and are compared each cycle to a reference model.
module tb_sdram_cmd_arbiter;

  localparam int NCH   = 3;
  localparam int CMDW  = 2;
  localparam int ADDRW = 23;
  localparam int TMO   = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       req;
  logic [NCH*CMDW-1:0]  cmd;
  logic [NCH*ADDRW-1:0] addr;
  logic                 rdv, wrv;
  logic [CMDW-1:0]      ack    [2];
  logic [CMDW-1:0]      o_cmd  [2];
  logic [ADDRW-1:0]     o_addr [2];
  logic [NCH-1:0]       o_gnt  [2];
  logic [NCH-1:0]       o_own  [2];
  logic [NCH-1:0]       o_rdv  [2];
  logic [NCH-1:0]       o_wrv  [2];
  logic                 o_busy [2];
  logic                 o_err  [2];

  always #5 clk = ~clk;

  sdram_cmd_arbiter #(.NCH(NCH), .CMDW(CMDW), .ADDRW(ADDRW), .MODE(0), .TMO(TMO)) u_fixed (
    .clk(clk), .rst(rst), .req_i(req), .cmd_i(cmd), .addr_i(addr),
    .sys_cmd_o(o_cmd[0]), .sys_addr_o(o_addr[0]), .sys_cmd_ack_i(ack[0]),
    .sys_rd_valid_i(rdv), .sys_wr_valid_i(wrv),
    .gnt_o(o_gnt[0]), .owner_o(o_own[0]), .rd_valid_o(o_rdv[0]), .wr_valid_o(o_wrv[0]),
    .busy_o(o_busy[0]), .err_o(o_err[0])
  );

  sdram_cmd_arbiter #(.NCH(NCH), .CMDW(CMDW), .ADDRW(ADDRW), .MODE(1), .TMO(TMO)) u_rr (
    .clk(clk), .rst(rst), .req_i(req), .cmd_i(cmd), .addr_i(addr),
    .sys_cmd_o(o_cmd[1]), .sys_addr_o(o_addr[1]), .sys_cmd_ack_i(ack[1]),
    .sys_rd_valid_i(rdv), .sys_wr_valid_i(wrv),
    .gnt_o(o_gnt[1]), .owner_o(o_own[1]), .rd_valid_o(o_rdv[1]), .wr_valid_o(o_wrv[1]),
    .busy_o(o_busy[1]), .err_o(o_err[1])
  );

  // Reference model, one slot per instance (index 0 fixed priority, 1 round-robin).
  int               m_busy [2], m_win [2], m_cmd [2], m_age [2];
  int               m_owner [2], m_gnt [2], m_rp [2], m_prev [2];
  bit               m_err [2];
  logic [ADDRW-1:0] m_addr [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int chan_cmd(input int k);
    return int'(cmd[k*CMDW +: CMDW]);
  endfunction

  function automatic logic [ADDRW-1:0] chan_addr(input int k);
    return addr[k*ADDRW +: ADDRW];
  endfunction

  function automatic logic [NCH-1:0] oh(input int i);
    logic [NCH-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 0; m_win[m] = 0; m_cmd[m] = 0; m_age[m] = 0; m_addr[m] = '0;
      m_owner[m] = -1; m_gnt[m] = -1; m_rp[m] = 0; m_prev[m] = 0; m_err[m] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("u%0d.sys_cmd", m), o_cmd[m], (m_busy[m] != 0) ? m_cmd[m] : 0);
      if (m_busy[m] != 0) check($sformatf("u%0d.sys_addr", m), o_addr[m], m_addr[m]);
      check($sformatf("u%0d.gnt", m), o_gnt[m], oh(m_gnt[m]));
      check($sformatf("u%0d.owner", m), o_own[m], oh(m_owner[m]));
      check($sformatf("u%0d.busy", m), o_busy[m], m_busy[m]);
      check($sformatf("u%0d.err", m), o_err[m], m_err[m]);
      check($sformatf("u%0d.rd_valid", m), o_rdv[m], rdv ? oh(m_owner[m]) : '0);
      check($sformatf("u%0d.wr_valid", m), o_wrv[m], wrv ? oh(m_owner[m]) : '0);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int a;
      bit rise;
      int w;
      a    = int'(ack[m]);
      rise = (a != 0) && (m_prev[m] == 0);
      m_gnt[m] = -1;
      if (m_busy[m] == 0) begin
        if (rise) m_err[m] = 1'b1;
        w = -1;
        for (int i = 0; i < NCH; i++) begin
          int k;
          k = (m == 1) ? (m_rp[m] + i) % NCH : i;
          if (w < 0 && req[k] && chan_cmd(k) != 0) w = k;
        end
        if (w >= 0) begin
          m_busy[m] = 1; m_win[m] = w; m_cmd[m] = chan_cmd(w);
          m_addr[m] = chan_addr(w); m_age[m] = 0;
        end
      end else if (rise && a == m_cmd[m]) begin
        m_gnt[m] = m_win[m];
        m_owner[m] = m_win[m];
        m_busy[m] = 0;
        if (m == 1) m_rp[m] = (m_win[m] + 1) % NCH;
      end else begin
        if (rise) m_err[m] = 1'b1;
        m_age[m]++;
        if (m_age[m] == TMO) begin
          m_err[m] = 1'b1;
          m_busy[m] = 0;
        end
      end
      m_prev[m] = a;
    end
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [NCH-1:0] r, input logic [CMDW-1:0] a,
                       input logic rd, input logic wr);
    req = r; ack[0] = a; ack[1] = a; rdv = rd; wrv = wr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("u%0d.rst_outputs", m),
            {o_cmd[m], o_addr[m], o_gnt[m], o_own[m], o_rdv[m], o_wrv[m], o_busy[m], o_err[m]},
            64'd0);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [NCH-1:0] rr_seq [4];
  int n_on, n_g, r;

  initial begin
    rst = 1'b1; req = '0; cmd = '0; rdv = 1'b0; wrv = 1'b0;
    ack[0] = '0; ack[1] = '0;
    addr = {23'h3c3c3, 23'h2aaaa, 23'h15555};
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;
    model_reset();
    @(negedge clk);

    // Timeout: single request, never acknowledged.
    do_reset();
    cmd = 6'b000001;
    drive(3'b001, 2'b00, 1'b0, 1'b0);
    tick();
    req = '0;
    n_on = 0; n_g = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_cmd[0] != '0) n_on++;
      if (o_gnt[0] != '0) n_g++;
      tick();
    end
    check("tmo_cmd_cycles", n_on, 4);
    check("tmo_no_gnt", n_g, 0);
    check("tmo_err", o_err[0], 1'b1);

    // Acknowledge edge while idle.
    do_reset();
    drive(3'b000, 2'b01, 1'b0, 1'b0);
    tick();
    check("idle_ack_err", o_err[0], 1'b1);
    check("idle_ack_owner", o_own[0], 3'b000);

    // Fixed priority with three requesters.
    do_reset();
    cmd = {2'b11, 2'b01, 2'b10};
    drive(3'b111, 2'b00, 1'b0, 1'b0);
    tick();
    check("fp_cmd", o_cmd[0], 2'b10);
    check("fp_addr", o_addr[0], 23'h15555);
    tick();
    drive(3'b111, 2'b10, 1'b0, 1'b0);
    tick();
    check("fp_gnt", o_gnt[0], 3'b001);
    check("fp_owner", o_own[0], 3'b001);

    // Round-robin rotation, back-to-back grants every three cycles.
    do_reset();
    cmd = 6'b010101;
    for (int g = 0; g < 4; g++) begin
      drive(3'b111, 2'b00, 1'b0, 1'b0);
      tick();
      tick();
      drive(3'b111, 2'b01, 1'b0, 1'b0);
      tick();
      check($sformatf("rr_gnt%0d", g), o_gnt[1], rr_seq[g]);
    end

    // Read strobe routing to owner channel 1.
    do_reset();
    cmd = 6'b000100;
    drive(3'b010, 2'b00, 1'b0, 1'b0);
    tick();
    tick();
    drive(3'b000, 2'b01, 1'b0, 1'b0);
    tick();
    check("own_ch1", o_own[0], 3'b010);
    drive(3'b000, 2'b00, 1'b1, 1'b0);
    n_on = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (o_rdv[0] == 3'b010) n_on++;
      tick();
    end
    check("rdv_cycles", n_on, 16);
    rdv = 1'b0;
    #1;
    check("rdv_off", o_rdv[0], 3'b000);
    tick();

    // Wrong acknowledge, then a fresh correct one.
    do_reset();
    cmd = 6'b000011;
    drive(3'b001, 2'b00, 1'b0, 1'b0);
    tick();
    drive(3'b000, 2'b00, 1'b0, 1'b0);
    tick();
    drive(3'b000, 2'b01, 1'b0, 1'b0);
    tick();
    check("bad_ack_err", o_err[0], 1'b1);
    check("bad_ack_busy", o_busy[0], 1'b1);
    drive(3'b000, 2'b00, 1'b0, 1'b0);
    tick();
    drive(3'b000, 2'b11, 1'b0, 1'b0);
    tick();
    check("good_ack_gnt", o_gnt[0], 3'b001);

    // Reset in the middle of ISSUE, request still pending.
    do_reset();
    cmd = 6'b000010;
    drive(3'b001, 2'b00, 1'b0, 1'b0);
    tick();
    check("pre_rst_busy", o_busy[0], 1'b1);
    do_reset();
    tick();
    check("post_rst_cmd", o_cmd[0], 2'b10);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      req  = NCH'($urandom);
      cmd  = (NCH*CMDW)'($urandom);
      addr = (NCH*ADDRW)'({$urandom(), $urandom(), $urandom()});
      for (int m = 0; m < 2; m++) begin
        r = int'($urandom_range(0, 9));
        if (m_busy[m] == 0)  ack[m] = (r < 9) ? '0 : CMDW'($urandom);
        else if (r < 4)      ack[m] = '0;
        else if (r < 8)      ack[m] = CMDW'(m_cmd[m]);
        else                 ack[m] = CMDW'($urandom);
      end
      rdv = 1'($urandom_range(0, 1));
      wrv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) do_reset();
      else tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_arbiter.md
SDRAM_CMD_ARBITER -- requirements
Module: sdram_cmd_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 3, giving the number of requesting channels (2..8).
REQ-002 SHALL have parameter CMDW, default 2, giving the SDRAM controller command code width.
REQ-003 SHALL have parameter ADDRW, default 23, giving the controller word address width.
REQ-004 SHALL have parameter MODE, default 0, selecting arbitration: 0 = fixed priority (channel 0 highest), 1 = round-robin.
REQ-005 SHALL have parameter TMO, default 255, giving the maximum number of cycles to wait for a command acknowledge.
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 req_i  in  NCH  level request per channel.
REQ-010 cmd_i  in  NCH*CMDW  command code per channel; channel k occupies bits [k*CMDW +: CMDW].
REQ-011 addr_i  in  NCH*ADDRW  word address per channel, packed the same way as cmd_i.
REQ-012 sys_cmd_o  out  CMDW  command to the controller; 0 = nop.
REQ-013 sys_addr_o  out  ADDRW  address accompanying sys_cmd_o.
REQ-014 sys_cmd_ack_i  in  CMDW  controller acknowledge code; nonzero while a command is accepted.
REQ-015 sys_rd_valid_i / sys_wr_valid_i  in  1 each  controller read-data-valid / write-data-valid strobes.
REQ-016 gnt_o  out  NCH  one-hot, one-cycle pulse marking the channel whose command was acknowledged.
REQ-017 owner_o  out  NCH  one-hot owner of the current data phase; all zero means no owner.
REQ-018 rd_valid_o / wr_valid_o  out  NCH each  data strobes routed to the owner.
REQ-019 busy_o  out  1  high while the state is ISSUE.
REQ-020 err_o  out  1  sticky error flag.

Function
REQ-021 SHALL treat a channel as eligible only when req_i[k]=1 and cmd_i[k] is nonzero.
REQ-022 SHALL implement two states, IDLE and ISSUE.
REQ-023 IDLE behaviour:
- sys_cmd_o = 0.
- When any channel is eligible, SHALL latch the winner index, its command and its address, and enter ISSUE on the next edge.
REQ-024 Winner selection:
- MODE=0: lowest eligible index wins.
- MODE=1: the first eligible index at or after the pointer rp, wrapping from NCH-1 to 0, wins.
REQ-025 ISSUE behaviour:
- sys_cmd_o and sys_addr_o SHALL hold the latched values, with no preemption.
- Changes on req_i, cmd_i or addr_i SHALL be ignored until the state leaves ISSUE.
REQ-026 Acknowledge qualification:
- An acknowledge SHALL be accepted only on a cycle where sys_cmd_ack_i is nonzero and its value in the previous cycle was zero (rising edge).
- A nonzero acknowledge that does not follow a zero cycle SHALL be ignored.
REQ-027 On an accepted acknowledge equal to the latched command, on the same edge:
- pulse gnt_o[winner] for one cycle;
- set owner_o to the winner;
- return to IDLE;
- in MODE=1, set rp to winner+1 mod NCH.
REQ-028 On an accepted acknowledge not equal to the latched command, SHALL set err_o, keep the command and remain in ISSUE.
REQ-029 A 0-to-nonzero acknowledge edge while in IDLE SHALL set err_o and leave owner_o unchanged.
REQ-030 Timeout:
- A counter SHALL clear on entry to ISSUE and increment each cycle in ISSUE.
- On reaching TMO without acknowledge, SHALL set err_o, drop the command (no gnt_o) and return to IDLE; owner_o is unchanged.
REQ-031 rd_valid_o SHALL equal owner_o AND sys_rd_valid_i, and wr_valid_o SHALL equal owner_o AND sys_wr_valid_i, combinationally; with owner_o=0 both strobes are discarded.
REQ-032 An acknowledge and data strobes arriving on the same cycle SHALL route the strobes to the old owner; the new owner takes effect from the next cycle.
REQ-033 Minimum request-to-command latency SHALL be 1 cycle (sys_cmd_o valid the cycle after req_i rises in IDLE). Back-to-back grants SHALL be possible every 2 cycles of ISSUE plus 1 cycle of IDLE.
REQ-034 err_o SHALL clear only on reset.

Reset
REQ-035 While rst=1, SHALL force:
- state to IDLE and rp to 0;
- all of the following to 0: sys_cmd_o, sys_addr_o, gnt_o, owner_o, busy_o, err_o, the timeout counter and the previous-acknowledge register.
REQ-036 Reset asserted during ISSUE SHALL abandon the command with no gnt_o pulse.
REQ-037 After rst falls, arbitration SHALL resume on the first clock edge.

Verification
REQ-038 MODE=0, NCH=3: req_i=3'b111, cmd_i={11,01,10}, ack=10 one cycle after issue -> sys_cmd_o=10 with addr of channel 0, gnt_o=001, owner_o=001.
REQ-039 MODE=1: all three channels requesting continuously, ack after each issue -> gnt_o sequence 001,010,100,001.
REQ-040 owner_o=010, hold sys_rd_valid_i=1 for 16 cycles -> rd_valid_o=010 for exactly those 16 cycles, with 0 on the other channels.
REQ-041 TMO=4, single request, no ack -> sys_cmd_o held 4 cycles then 0, err_o=1, no gnt_o.
REQ-042 Issue command 11, ack=01 -> err_o=1, state stays ISSUE; a later fresh ack=11 -> gnt_o pulses.
REQ-043 Assert rst mid-ISSUE -> all outputs 0 immediately; after release, a pending request issues on the next cycle.
